// File: rtl/bg_layer_fetch.sv
// bg_layer_fetch: streams a 16-bpp background image from SDRAM through a
// prefetch FIFO and composites it with the core's 12-bit foreground.
// Ports: clk, RESET_L (sync, active low); video timing ce_pix, hblank,
// vblank, vs; enable, mode, fg_rgb; SDRAM read port mem_req, mem_addr,
// mem_ack, mem_data ({b,a,r,g}); outputs rgb_out ({r,g,b}), underrun.
module bg_layer_fetch #(
    parameter int AW          = 25,
    parameter int DEPTH       = 8,
    parameter int STEP        = 2,
    parameter int FRAME_WORDS = 307200
) (
    input  logic          clk,
    input  logic          RESET_L,
    input  logic          ce_pix,
    input  logic          hblank,
    input  logic          vblank,
    input  logic          vs,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [11:0]   fg_rgb,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [15:0]   mem_data,
    output logic [11:0]   rgb_out,
    output logic          underrun
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(FRAME_WORDS + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_skip;
    logic [CW-1:0] r_wcnt;
    logic          r_drop;
    logic          r_vs_d;
    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;

    logic          w_fs;
    logic          w_pix;
    logic          w_pop;
    logic          w_under;
    logic          w_ack;
    logic          w_push;
    logic          w_skip_dec;
    logic          w_issue;
    logic [AW-1:0] w_skip_nx;
    logic [15:0]   w_word;
    logic [3:0]    w_a;
    logic [11:0]   w_bg;
    logic [11:0]   w_blend;
    logic [11:0]   w_mix;

    assign w_fs    = vs & ~r_vs_d;
    assign w_pix   = ce_pix & ~(hblank | vblank) & enable;
    assign w_pop   = w_pix & (r_cnt != '0);
    assign w_under = w_pix & (r_cnt == '0);
    // Acks are only honoured in WAIT, so a late ack after reset is ignored.
    // An ack coinciding with frame start belongs to the old frame.
    assign w_ack      = (r_state == S_WAIT) & mem_ack & ~w_fs;
    assign w_push     = w_ack & ~r_drop & (r_skip == '0);
    assign w_skip_dec = w_ack & ~r_drop & (r_skip != '0);
    // No outstanding request exists in IDLE, so fifo space alone decides.
    assign w_issue = (r_state == S_IDLE) & enable & ~w_fs
                   & (r_cnt < (PW+1)'(DEPTH))
                   & (r_wcnt < CW'(FRAME_WORDS));

    always_comb begin
        w_skip_nx = r_skip;
        if (w_skip_dec)
            w_skip_nx = w_skip_nx - 1'b1;
        if (w_under && w_skip_nx != '1)
            w_skip_nx = w_skip_nx + 1'b1;
    end

    function automatic logic [3:0] blend(
        input logic [3:0] f,
        input logic [3:0] b,
        input logic [3:0] a
    );
        logic [7:0] s;
        s = {4'd0, f} * (8'd16 - {4'd0, a}) + {4'd0, b} * {4'd0, a};
        return s[7:4];
    endfunction

    // Empty fifo, blank and disabled all read as transparent black, a=0.
    assign w_word  = w_pop ? r_mem[r_rp] : 16'h0000;
    assign w_a     = w_word[11:8];
    assign w_bg    = {w_word[7:4], w_word[3:0], w_word[15:12]};
    assign w_blend = {blend(fg_rgb[11:8], w_bg[11:8], w_a),
                      blend(fg_rgb[7:4],  w_bg[7:4],  w_a),
                      blend(fg_rgb[3:0],  w_bg[3:0],  w_a)};

    always_comb begin
        w_mix = fg_rgb;
        unique case (mode)
            2'd0: w_mix = fg_rgb;
            2'd1: w_mix = (fg_rgb != '0 && w_a == '0) ? fg_rgb : w_bg;
            2'd2: w_mix = (fg_rgb == '0) ? w_bg : w_blend;
            2'd3: w_mix = w_bg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= mem_data;
    end

    always_ff @(posedge clk) begin
        if (!RESET_L) begin
            r_state  <= S_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            r_addr   <= '0;
            r_wcnt   <= '0;
            r_skip   <= '0;
            r_drop   <= 1'b0;
            r_vs_d   <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            rgb_out  <= '0;
            underrun <= 1'b0;
        end else begin
            r_vs_d  <= vs;
            mem_req <= 1'b0;
            r_skip  <= w_skip_nx;
            if (ce_pix)
                rgb_out <= w_mix;
            if (w_under)
                underrun <= 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        mem_req  <= 1'b1;
                        mem_addr <= r_addr;
                        r_addr   <= r_addr + AW'(STEP);
                        r_wcnt   <= r_wcnt + 1'b1;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack)
                        r_state <= S_IDLE;
                end
            endcase

            if (w_ack)
                r_drop <= 1'b0;

            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);

            if (w_fs) begin
                r_addr <= '0;
                r_wcnt <= '0;
                r_skip <= '0;
                r_wp   <= '0;
                r_rp   <= '0;
                r_cnt  <= '0;
                // Stale response still to come: stay in WAIT and discard it.
                r_drop <= (r_state == S_WAIT) & ~mem_ack;
            end
        end
    end
endmodule

// File: tb/tb_bg_layer_fetch.sv
// tb_bg_layer_fetch: scoreboard bench for bg_layer_fetch with two
// instances (full frame and a 4-word frame) and latency memory models.
module tb_bg_layer_fetch;
    localparam int AW = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          RESET_L;
    logic          ce_pix;
    logic          hblank;
    logic          vblank;
    logic          vs;
    logic          enable;
    logic [1:0]    mode;
    logic [11:0]   fg_rgb;

    logic          req   [2];
    logic [AW-1:0] maddr [2];
    logic          ack   [2];
    logic [15:0]   mdata [2];
    logic [11:0]   rgb   [2];
    logic          und   [2];

    int            lat   [2];
    int            cnt   [2];
    bit            pend  [2];
    logic [AW-1:0] paddr [2];
    int            nreq  [2];

    logic [AW-1:0] q_addr [$];
    logic [11:0]   sb0 [$];
    logic [11:0]   sb1 [$];
    logic [15:0]   img [64];

    int n_assert = 0;
    int n_fail   = 0;

    bg_layer_fetch u_dut (
        .clk(clk), .RESET_L(RESET_L), .ce_pix(ce_pix),
        .hblank(hblank), .vblank(vblank), .vs(vs),
        .enable(enable), .mode(mode), .fg_rgb(fg_rgb),
        .mem_req(req[0]), .mem_addr(maddr[0]),
        .mem_ack(ack[0]), .mem_data(mdata[0]),
        .rgb_out(rgb[0]), .underrun(und[0])
    );

    bg_layer_fetch #(.FRAME_WORDS(4)) u_dut4 (
        .clk(clk), .RESET_L(RESET_L), .ce_pix(ce_pix),
        .hblank(hblank), .vblank(vblank), .vs(vs),
        .enable(enable), .mode(mode), .fg_rgb(fg_rgb),
        .mem_req(req[1]), .mem_addr(maddr[1]),
        .mem_ack(ack[1]), .mem_data(mdata[1]),
        .rgb_out(rgb[1]), .underrun(und[1])
    );

    // Memory models: ack a fixed number of clocks after each request.
    always @(negedge clk) begin : mem_model
        int idx;
        for (int k = 0; k < 2; k++) begin
            ack[k] = 1'b0;
            if (pend[k]) begin
                if (cnt[k] <= 1) begin
                    idx = int'(paddr[k] >> 1) % 64;
                    ack[k]   = 1'b1;
                    mdata[k] = img[idx];
                    pend[k]  = 1'b0;
                end else begin
                    cnt[k] = cnt[k] - 1;
                end
            end
            if (req[k] === 1'b1) begin
                pend[k]  = 1'b1;
                cnt[k]   = lat[k];
                paddr[k] = maddr[k];
                nreq[k]  = nreq[k] + 1;
                if (k == 0)
                    q_addr.push_back(maddr[k]);
            end
        end
    end

    function automatic logic [15:0] mk(
        input logic [3:0] b, input logic [3:0] a,
        input logic [3:0] r, input logic [3:0] g
    );
        return {b, a, r, g};
    endfunction

    function automatic logic [11:0] model(
        input logic [11:0] fg, input logic [15:0] w, input logic [1:0] m
    );
        int a, f, b, o;
        logic [11:0] bg, bl;
        a  = int'(w[11:8]);
        bg = {w[7:4], w[3:0], w[15:12]};
        bl = '0;
        for (int c = 0; c < 3; c++) begin
            f  = int'((fg >> (4 * c)) & 12'hF);
            b  = int'((bg >> (4 * c)) & 12'hF);
            o  = ((f * (16 - a) + b * a) >> 4) & 15;
            bl = bl | (12'(o) << (4 * c));
        end
        case (m)
            2'd0:    return fg;
            2'd1:    return (fg != 0 && a == 0) ? fg : bg;
            2'd2:    return (fg == 0) ? bg : bl;
            default: return bg;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] seed);
        for (int i = 0; i < 64; i++)
            img[i] = seed + 16'(i) * 16'h1111;
    endtask

    task automatic frame();
        @(posedge clk);
        #1 vs = 1'b1;
        @(posedge clk);
        #1 vs = 1'b0;
        q_addr.delete();
        nreq[0] = 0;
        nreq[1] = 0;
    endtask

    // One ce_pix pulse; the expected main-instance output goes on sb0.
    task automatic drive_pix(input bit act, input logic [15:0] w);
        @(posedge clk);
        #1;
        ce_pix = 1'b1;
        hblank = !act;
        sb0.push_back(model(fg_rgb, act ? w : 16'h0000, mode));
        @(posedge clk);
        #1;
        ce_pix = 1'b0;
        hblank = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int t;
        t = 0;
        while (req[0] !== 1'b1 && t < 100) begin
            tick(1);
            t++;
        end
        ok = (req[0] === 1'b1);
    endtask

    task automatic test_reset();
        RESET_L = 1'b0;
        enable  = 1'b0;
        ce_pix  = 1'b0;
        hblank  = 1'b0;
        vblank  = 1'b0;
        vs      = 1'b0;
        mode    = 2'd3;
        fg_rgb  = '0;
        tick(4);
        n_assert++;
        if (req[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req: got %b expected 0", req[0]);
        end
        n_assert++;
        if (maddr[0] !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h expected 0", maddr[0]);
        end
        n_assert++;
        if (rgb[0] !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_rgb: got %h expected 000", rgb[0]);
        end
        n_assert++;
        if (und[0] !== 1'b0 || und[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_underrun: got %b%b expected 00", und[0], und[1]);
        end
        RESET_L = 1'b1;
        tick(1);
    endtask

    task automatic test_frame_limit();
        logic [11:0] e0, e1;
        fill(16'h1234);
        mode   = 2'd3;
        enable = 1'b1;
        frame();
        tick(100);
        n_assert++;
        if (nreq[1] != 4) begin
            n_fail++;
            $display("FAIL limit_reqs: got %0d expected 4", nreq[1]);
        end
        for (int i = 0; i < 5; i++) begin
            sb1.push_back(model(fg_rgb, (i < 4) ? img[i] : 16'h0000, mode));
            drive_pix(1'b1, img[i]);
            e0 = sb0.pop_front();
            e1 = sb1.pop_front();
            n_assert++;
            if (rgb[0] !== e0) begin
                n_fail++;
                $display("FAIL limit_main_pix%0d: got %h expected %h", i, rgb[0], e0);
            end
            n_assert++;
            if (rgb[1] !== e1) begin
                n_fail++;
                $display("FAIL limit_pix%0d: got %h expected %h", i, rgb[1], e1);
            end
            n_assert++;
            if (und[1] !== (i == 4)) begin
                n_fail++;
                $display("FAIL limit_underrun%0d: got %b expected %b", i, und[1], i == 4);
            end
        end
        tick(50);
        n_assert++;
        if (nreq[1] != 4) begin
            n_fail++;
            $display("FAIL limit_reqs_after: got %0d expected 4", nreq[1]);
        end
    endtask

    task automatic test_stream();
        logic [11:0] e;
        for (int i = 0; i < 64; i++)
            img[i] = 16'(i);
        lat[0] = 3;
        mode   = 2'd3;
        frame();
        tick(60);
        for (int i = 0; i < 12; i++) begin
            drive_pix(1'b1, img[i]);
            e = sb0.pop_front();
            n_assert++;
            if (rgb[0] !== e) begin
                n_fail++;
                $display("FAIL stream_pix%0d: got %h expected %h", i, rgb[0], e);
            end
        end
        n_assert++;
        if (und[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_underrun: got %b expected 0", und[0]);
        end
        n_assert++;
        if (q_addr.size() < 8) begin
            n_fail++;
            $display("FAIL stream_nreq: got %0d expected >=8", q_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_assert++;
                if (q_addr[i] !== AW'(2 * i)) begin
                    n_fail++;
                    $display("FAIL stream_addr%0d: got %h expected %h", i, q_addr[i], 2 * i);
                end
            end
        end
    endtask

    task automatic test_colour_key();
        logic [11:0] fgs [6];
        logic        act [6];
        logic [11:0] e;
        int          n;
        img[0] = mk(4'h3, 4'h0, 4'h1, 4'h2);
        img[1] = mk(4'h3, 4'h5, 4'h1, 4'h2);
        img[2] = mk(4'h6, 4'h0, 4'h4, 4'h5);
        img[3] = mk(4'h9, 4'h5, 4'h7, 4'h8);
        img[4] = mk(4'hC, 4'h5, 4'hA, 4'hB);
        fgs = '{12'hF00, 12'hF00, 12'h000, 12'h000, 12'hF00, 12'hF00};
        act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        mode = 2'd1;
        frame();
        tick(60);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            fg_rgb = fgs[i];
            drive_pix(act[i], img[n]);
            if (act[i])
                n++;
            e = sb0.pop_front();
            n_assert++;
            if (rgb[0] !== e) begin
                n_fail++;
                $display("FAIL ckey_pix%0d: got %h expected %h", i, rgb[0], e);
            end
        end
    endtask

    task automatic test_alpha();
        logic [11:0] fgs [5];
        logic [11:0] e;
        img[0] = mk(4'h0, 4'h8, 4'h0, 4'h0);
        img[1] = mk(4'h9, 4'h0, 4'h0, 4'h5);
        img[2] = mk(4'h2, 4'h7, 4'h4, 4'h6);
        img[3] = mk(4'h2, 4'h3, 4'h4, 4'hF);
        img[4] = mk(4'h0, 4'hF, 4'h0, 4'h0);
        fgs = '{12'hF00, 12'hF00, 12'h000, 12'h8C4, 12'hFFF};
        mode = 2'd2;
        frame();
        tick(60);
        for (int i = 0; i < 5; i++) begin
            fg_rgb = fgs[i];
            drive_pix(1'b1, img[i]);
            e = sb0.pop_front();
            n_assert++;
            if (rgb[0] !== e) begin
                n_fail++;
                $display("FAIL alpha_pix%0d: got %h expected %h", i, rgb[0], e);
            end
        end
        fg_rgb = '0;
    endtask

    task automatic test_underrun();
        logic [11:0] e;
        fill(16'h5A3C);
        lat[0] = 20;
        mode   = 2'd3;
        n_assert++;
        if (und[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL under_pre: got %b expected 0", und[0]);
        end
        frame();
        for (int i = 0; i < 3; i++) begin
            drive_pix(1'b1, 16'h0000);
            e = sb0.pop_front();
            n_assert++;
            if (rgb[0] !== e) begin
                n_fail++;
                $display("FAIL under_empty%0d: got %h expected %h", i, rgb[0], e);
            end
        end
        n_assert++;
        if (und[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL under_flag: got %b expected 1", und[0]);
        end
        tick(400);
        for (int i = 3; i < 7; i++) begin
            drive_pix(1'b1, img[i]);
            e = sb0.pop_front();
            n_assert++;
            if (rgb[0] !== e) begin
                n_fail++;
                $display("FAIL under_align%0d: got %h expected %h", i, rgb[0], e);
            end
        end
    endtask

    task automatic test_vs_wait();
        logic [11:0] e;
        bit ok;
        fill(16'h9E71);
        lat[0] = 20;
        mode   = 2'd3;
        frame();
        tick(100);
        wait_req(ok);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL vsw_req_timeout: got no request expected one");
        end
        tick(3);
        frame();
        n_assert++;
        if (und[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL vsw_sticky: got %b expected 1", und[0]);
        end
        drive_pix(1'b1, 16'h0000);
        e = sb0.pop_front();
        n_assert++;
        if (rgb[0] !== e) begin
            n_fail++;
            $display("FAIL vsw_flush: got %h expected %h", rgb[0], e);
        end
        tick(400);
        for (int i = 1; i < 4; i++) begin
            drive_pix(1'b1, img[i]);
            e = sb0.pop_front();
            n_assert++;
            if (rgb[0] !== e) begin
                n_fail++;
                $display("FAIL vsw_pix%0d: got %h expected %h", i, rgb[0], e);
            end
        end
        n_assert++;
        if (q_addr.size() < 2 || q_addr[0] !== '0 || q_addr[1] !== AW'(2)) begin
            n_fail++;
            $display("FAIL vsw_addr: got n=%0d first %h expected first 0 then 2",
                     q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : '1);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        bit ok;
        fill(16'h3C5A);
        lat[0] = 3;
        mode   = 2'd3;
        frame();
        tick(100);
        for (int i = 0; i < 2; i++) begin
            drive_pix(1'b1, img[i]);
            e = sb0.pop_front();
            n_assert++;
            if (rgb[0] !== e) begin
                n_fail++;
                $display("FAIL rmid_pix%0d: got %h expected %h", i, rgb[0], e);
            end
        end
        n_assert++;
        if (und[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_sticky: got %b expected 1", und[0]);
        end
        wait_req(ok);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rmid_req_timeout: got no request expected one");
        end
        RESET_L = 1'b0;
        tick(1);
        n_assert++;
        if (req[0] !== 1'b0 || maddr[0] !== '0) begin
            n_fail++;
            $display("FAIL rmid_req: got %b/%h expected 0/0", req[0], maddr[0]);
        end
        n_assert++;
        if (rgb[0] !== 12'h000 || rgb[1] !== 12'h000) begin
            n_fail++;
            $display("FAIL rmid_rgb: got %h/%h expected 000/000", rgb[0], rgb[1]);
        end
        n_assert++;
        if (und[0] !== 1'b0 || und[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_underrun: got %b%b expected 00", und[0], und[1]);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ack[k]   = 1'b0;
            mdata[k] = '0;
            lat[k]   = 3;
            cnt[k]   = 0;
            pend[k]  = 1'b0;
            paddr[k] = '0;
            nreq[k]  = 0;
        end
        for (int i = 0; i < 64; i++)
            img[i] = '0;
        test_reset();
        test_frame_limit();
        test_stream();
        test_colour_key();
        test_alpha();
        test_underrun();
        test_vs_wait();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
